pmem_arbiter: RTL

- Shares the single physical-memory cacheline port between the instruction-cache miss path and the data-cache miss/writeback path.
- Sits between the two caches and the cacheline adaptor.
- Serializes requests with a round-robin grant and latches address and write data at grant time.
- Returns the read line to the granted requester with a one-cycle response pulse.

---
 rtl/pmem_arbiter_pkg.sv | 31 +++
 rtl/pmem_arbiter_reg.sv | 28 ++
 rtl/pmem_arbiter.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/pmem_arbiter_pkg.sv
// ============================================================================
// Module  : arb_types (package)
// Brief   : Shared types and constants for the physical-memory arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

package arb_types;

    localparam int OFFSET_W = 5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        DONE    = 2'd3
    } arb_state_t;

    typedef enum logic [0:0] {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } grant_t;

    typedef enum logic [0:0] {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } arb_op_t;

endpackage

`default_nettype wire

// File: rtl/pmem_arbiter_reg.sv
// ============================================================================
// Module  : pmem_arbiter_reg
// Brief   : Parameterized load-enabled register with asynchronous reset.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pmem_arbiter_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/pmem_arbiter.sv
// ============================================================================
// Module  : pmem_arbiter
// Brief   : Round-robin arbiter sharing one cacheline memory port between
//           the I-cache and D-cache miss paths.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pmem_arbiter #(
    parameter int LINE_W   = 256,
    parameter int ADDR_W   = 32,
    parameter int OFFSET_W = arb_types::OFFSET_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp
);

    import arb_types::*;

    localparam logic [ADDR_W-1:0] C_ALIGN_MASK =
        {{(ADDR_W-OFFSET_W){1'b1}}, {OFFSET_W{1'b0}}};

    arb_state_t        r_state;
    grant_t            r_last_grant;
    arb_op_t           r_op;

    logic              w_i_req;
    logic              w_d_req;
    logic              w_grant_valid;
    grant_t            w_grant;
    arb_op_t           w_op;
    logic [ADDR_W-1:0] w_addr_aligned;
    logic              w_addr_load;
    logic              w_wdata_load;
    logic              w_iline_load;
    logic              w_dline_load;

    assign w_i_req       = i_read;
    assign w_d_req       = d_read | d_write;
    assign w_grant_valid = w_i_req | w_d_req;

    // On a tie the requester that did not win last time gets the port.
    always_comb begin
        w_grant = GNT_I;
        if (w_i_req && w_d_req) begin
            w_grant = (r_last_grant == GNT_I) ? GNT_D : GNT_I;
        end else if (w_d_req) begin
            w_grant = GNT_D;
        end
    end

    always_comb begin
        w_op = OP_READ;
        if (w_grant == GNT_D && d_write) begin
            w_op = OP_WRITE;
        end
    end

    assign w_addr_aligned = ((w_grant == GNT_D) ? d_addr : i_addr) & C_ALIGN_MASK;
    assign w_addr_load    = (r_state == IDLE) && w_grant_valid;
    assign w_wdata_load   = w_addr_load && (w_grant == GNT_D);
    assign w_iline_load   = (r_state == SERVE_I) && mem_resp && (r_op == OP_READ);
    assign w_dline_load   = (r_state == SERVE_D) && mem_resp && (r_op == OP_READ);

    pmem_arbiter_reg #(.WIDTH(ADDR_W)) u_addr_reg (
        .clk  (clk),
        .rst  (rst),
        .load (w_addr_load),
        .d    (w_addr_aligned),
        .q    (mem_addr)
    );

    pmem_arbiter_reg #(.WIDTH(LINE_W)) u_wdata_reg (
        .clk  (clk),
        .rst  (rst),
        .load (w_wdata_load),
        .d    (d_wdata),
        .q    (mem_wdata)
    );

    pmem_arbiter_reg #(.WIDTH(LINE_W)) u_iline_reg (
        .clk  (clk),
        .rst  (rst),
        .load (w_iline_load),
        .d    (mem_rdata),
        .q    (i_rdata)
    );

    pmem_arbiter_reg #(.WIDTH(LINE_W)) u_dline_reg (
        .clk  (clk),
        .rst  (rst),
        .load (w_dline_load),
        .d    (mem_rdata),
        .q    (d_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_last_grant <= GNT_I;
            r_op         <= OP_READ;
            mem_read     <= 1'b0;
            mem_write    <= 1'b0;
            i_resp       <= 1'b0;
            d_resp       <= 1'b0;
        end else begin
            assert (!(d_read && d_write))
                else $error("pmem_arbiter: d_read and d_write both asserted");
            assert (!(mem_resp && r_state != SERVE_I && r_state != SERVE_D))
                else $error("pmem_arbiter: mem_resp outside a service state");

            i_resp <= 1'b0;
            d_resp <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_grant_valid) begin
                        r_last_grant <= w_grant;
                        r_op         <= w_op;
                        mem_read     <= (w_op == OP_READ);
                        mem_write    <= (w_op == OP_WRITE);
                        r_state      <= (w_grant == GNT_I) ? SERVE_I : SERVE_D;
                    end
                end
                SERVE_I, SERVE_D: begin
                    if (mem_resp) begin
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        i_resp    <= (r_state == SERVE_I);
                        d_resp    <= (r_state == SERVE_D);
                        r_state   <= DONE;
                    end
                end
                // Requests are deliberately not sampled here so a level still
                // held during the response cycle is not serviced twice.
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
